// File: rtl/ex_mem_req_unit.sv
// EX-stage memory request unit: alignment check, strobe/lane build, single
// outstanding bus request, in-order metadata FIFO for responses, flush cancel.
module ex_mem_req_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_wdata,
   input  logic [1:0]          in_size,
   input  logic                in_we,
   input  logic                in_signed,
   output logic                ale,
   input  logic                flush,
   output logic                req,
   output logic                wr,
   output logic [1:0]          size,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   wdata,
   input  logic                addr_ok,
   input  logic                data_ok,
   input  logic [DATA_W-1:0]   rdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                proto_err
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic             cancel;
      logic             we;
      logic [1:0]       size;
      logic             sgn;
      logic [OFF_W-1:0] off;
   } meta_t;

   state_t            state, state_n;
   logic              misalign, accept, go, push, pop;
   logic [NB-1:0]     strb_n;
   logic [DATA_W-1:0] wdata_n;
   logic [OFF_W-1:0]  in_off;
   logic              l_sgn, l_cancel;
   meta_t             fifo [MAX_OUT];
   meta_t             head_m;
   logic [PTR_W-1:0]  head, tail;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shifted;
   logic              msb;
   int                nbits;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_off   = in_addr[OFF_W-1:0];
   assign in_ready = (state == IDLE) && (cnt < CNT_W'(MAX_OUT)) && !flush;
   assign accept   = in_valid & in_ready;
   assign go       = accept & ~ale;
   assign req      = (state == REQ);
   assign push     = req & addr_ok;
   assign pop      = data_ok & (cnt != '0);

   // Size legality and natural alignment; dword only exists on a 64-bit bus
   always_comb begin
      misalign = 1'b0;
      case (in_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = in_addr[0];
         2'd2:    misalign = |in_addr[1:0];
         default: misalign = (DATA_W != 64) | (|in_addr[2:0]);
      endcase
   end
   assign ale = in_valid & misalign;

   // Byte strobes at the access offset and store data replicated across lanes
   always_comb begin
      strb_n  = '0;
      wdata_n = '0;
      case (in_size)
         2'd0: begin
            strb_n = NB'(1) << in_off;
            for (int i = 0; i < NB; i++) wdata_n[8*i +: 8] = in_wdata[7:0];
         end
         2'd1: begin
            strb_n = NB'(2'b11) << in_off;
            for (int i = 0; i < NB/2; i++) wdata_n[16*i +: 16] = in_wdata[15:0];
         end
         2'd2: begin
            strb_n = NB'(4'hF) << in_off;
            for (int i = 0; i < NB/4; i++) wdata_n[32*i +: 32] = in_wdata[31:0];
         end
         default: begin
            strb_n  = '1;
            wdata_n = in_wdata;
         end
      endcase
      if (!in_we) strb_n = '0;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state: one request in flight on the address channel at a time
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (go) state_n = REQ;
         REQ:     if (addr_ok) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Latched bus fields; held stable while req waits for addr_ok
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr       <= 1'b0;
         size     <= '0;
         addr     <= '0;
         wstrb    <= '0;
         wdata    <= '0;
         l_sgn    <= 1'b0;
         l_cancel <= 1'b0;
      end else if (go) begin
         wr       <= in_we;
         size     <= in_size;
         addr     <= in_addr;
         wstrb    <= strb_n;
         wdata    <= wdata_n;
         l_sgn    <= in_signed;
         l_cancel <= 1'b0;
      end else if (flush) begin
         l_cancel <= 1'b1;
      end
   end

   // Metadata FIFO of accepted-but-unanswered accesses; flush marks all cancelled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < MAX_OUT; i++) fifo[i] <= '0;
      end else begin
         if (flush)
            for (int i = 0; i < MAX_OUT; i++) fifo[i].cancel <= 1'b1;
         if (push) begin
            fifo[tail] <= '{cancel: l_cancel | flush, we: wr, size: size,
                            sgn: l_sgn, off: addr[OFF_W-1:0]};
            tail <= nxt(tail);
         end
         if (pop) head <= nxt(head);
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Sticky protocol error: completion with nothing outstanding
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                       proto_err <= 1'b0;
      else if (data_ok && cnt == '0)   proto_err <= 1'b1;
   end

   // Load return: align by head offset, truncate to size, sign/zero extend
   always_comb begin
      head_m  = fifo[head];
      shifted = rdata >> {head_m.off, 3'b000};
      case (head_m.size)
         2'd0:    begin nbits = 8;      msb = shifted[7];        end
         2'd1:    begin nbits = 16;     msb = shifted[15];       end
         2'd2:    begin nbits = 32;     msb = shifted[31];       end
         default: begin nbits = DATA_W; msb = shifted[DATA_W-1]; end
      endcase
      rsp_data = shifted;
      for (int i = 0; i < DATA_W; i++)
         if (i >= nbits) rsp_data[i] = head_m.sgn & msb;
      if (head_m.we) rsp_data = '0;
   end

   assign rsp_valid = pop & ~head_m.cancel & ~flush;

endmodule
